// File: rtl/sha256_pad_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_pad_if
// Brief    : Word-in / block-out handshake bundle for the SHA-256 padder.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_pad_if;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] blk_o;
    logic         blk_first;
    logic         blk_last;
    logic         blk_valid;
    logic         blk_ready;

    // slave: the padder itself; master: the surrounding hash front end / controller
    modport slave (
        input  in_data, in_bytes, in_last, in_valid, blk_ready,
        output in_ready, blk_o, blk_first, blk_last, blk_valid
    );
    modport master (
        output in_data, in_bytes, in_last, in_valid, blk_ready,
        input  in_ready, blk_o, blk_first, blk_last, blk_valid
    );
endinterface
`default_nettype wire

// File: rtl/sha256_pad.sv
`default_nettype none
// ============================================================================
// Module   : sha256_pad
// Brief    : Streaming SHA-256 padder; emits 512-bit blocks, W0 in [31:0].
//            Define SHA256_PAD_PRELOAD_EN to add the pre_blocks length preload.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_pad (
    input  wire logic       clk,
    input  wire logic       rst,
`ifdef SHA256_PAD_PRELOAD_EN
    input  wire logic [7:0] pre_blocks,
`endif
    sha256_pad_if.slave     bus
);
    localparam logic [1:0] c_ST_FILL = 2'd0;
    localparam logic [1:0] c_ST_PAD  = 2'd1;
    localparam logic [1:0] c_ST_EMIT = 2'd2;

    logic [1:0]        r_state;
    logic [15:0][31:0] r_buf;
    logic [3:0]        r_widx;
    logic [63:0]       r_len;
    logic              r_first;
    logic              r_last;
    logic              r_mark80;
    logic              r_len_ok;
    logic              r_ended;
    logic              r_started;
    logic              r_in_ready;
    logic              r_blk_valid;

    logic [2:0]        w_nbytes;
    logic [31:0]       w_word;
    logic [63:0]       w_len_base;
    logic              w_accept;
    logic              w_take;

    assign w_accept = r_in_ready & bus.in_valid;
    assign w_take   = r_blk_valid & bus.blk_ready;

    // r_len is zero whenever no message is in flight, so the base only differs with preload
`ifdef SHA256_PAD_PRELOAD_EN
    assign w_len_base = r_started ? r_len : {47'd0, pre_blocks, 9'd0};
`else
    assign w_len_base = r_started ? r_len : 64'd0;
`endif

    always_comb begin
        w_nbytes = 3'd4;
        if (bus.in_last && (bus.in_bytes < 3'd4)) begin
            w_nbytes = bus.in_bytes;
        end
    end

    always_comb begin
        w_word = bus.in_data;
        case (w_nbytes)
            3'd1:    w_word = {bus.in_data[31:24], 8'h80, 16'h0000};
            3'd2:    w_word = {bus.in_data[31:16], 8'h80, 8'h00};
            3'd3:    w_word = {bus.in_data[31:8],  8'h80};
            default: w_word = bus.in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_FILL;
            r_buf       <= '0;
            r_widx      <= 4'd0;
            r_len       <= 64'd0;
            r_first     <= 1'b1;
            r_last      <= 1'b0;
            r_mark80    <= 1'b0;
            r_len_ok    <= 1'b0;
            r_ended     <= 1'b0;
            r_started   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_blk_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_FILL: begin
                    if (w_accept) begin
                        r_started <= 1'b1;
                        r_len_ok  <= 1'b0;
                        r_len     <= w_len_base + {58'd0, w_nbytes, 3'd0};
                        if (bus.in_last) begin
                            r_ended <= 1'b1;
                        end
                        if (bus.in_last && (w_nbytes == 3'd0)) begin
                            r_mark80   <= 1'b0;
                            r_state    <= c_ST_PAD;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_buf[r_widx] <= w_word;
                            r_widx        <= r_widx + 4'd1;
                            if (bus.in_last) begin
                                r_mark80 <= (w_nbytes != 3'd4);
                            end
                            r_in_ready <= 1'b0;
                            if (r_widx == 4'd15) begin
                                r_state     <= c_ST_EMIT;
                                r_blk_valid <= 1'b1;
                            end else if (bus.in_last) begin
                                r_state <= c_ST_PAD;
                            end else begin
                                r_in_ready <= 1'b1;
                            end
                        end
                    end
                end

                c_ST_PAD: begin
                    // Length only fits if the 0x80 marker landed before word 14
                    if (!r_mark80) begin
                        r_buf[r_widx] <= 32'h8000_0000;
                        r_mark80      <= 1'b1;
                    end else if (r_widx == 4'd14) begin
                        r_buf[r_widx] <= r_len[63:32];
                        r_len_ok      <= 1'b1;
                    end else if (r_widx == 4'd15) begin
                        r_buf[r_widx] <= r_len_ok ? r_len[31:0] : 32'd0;
                        r_last        <= r_len_ok;
                    end else begin
                        r_buf[r_widx] <= 32'd0;
                    end
                    r_widx <= r_widx + 4'd1;
                    if (r_widx == 4'd15) begin
                        r_state     <= c_ST_EMIT;
                        r_blk_valid <= 1'b1;
                    end
                end

                c_ST_EMIT: begin
                    if (w_take) begin
                        r_blk_valid <= 1'b0;
                        r_widx      <= 4'd0;
                        r_len_ok    <= 1'b0;
                        if (r_last) begin
                            r_buf      <= '0;
                            r_len      <= 64'd0;
                            r_first    <= 1'b1;
                            r_last     <= 1'b0;
                            r_mark80   <= 1'b0;
                            r_ended    <= 1'b0;
                            r_started  <= 1'b0;
                            r_state    <= c_ST_FILL;
                            r_in_ready <= 1'b1;
                        end else if (r_ended) begin
                            r_first <= 1'b0;
                            r_state <= c_ST_PAD;
                        end else begin
                            r_first    <= 1'b0;
                            r_state    <= c_ST_FILL;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state    <= c_ST_FILL;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.blk_o     = r_buf;
    assign bus.blk_first = r_first;
    assign bus.blk_last  = r_last;
    assign bus.blk_valid = r_blk_valid;
endmodule
`default_nettype wire

// File: tb/tb_sha256_pad.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_pad
// Brief    : Randomized bench for sha256_pad against a byte-level padding model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_pad;
    typedef logic [7:0] u8_t;
    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [7:0]   pre_blocks;
    int           n_tests;
    int           n_fail;
    int           rdy_mode;
    bit           gap_en;
    exp_t         exp_q[$];
    logic [511:0] last_blk;

    sha256_pad_if bus();

    sha256_pad dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SHA256_PAD_PRELOAD_EN
        .pre_blocks (pre_blocks),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: FIPS 180-4 padding on a byte array, then split into 64-byte blocks
    task automatic model_push(input u8_t msg[$], input int pre);
        u8_t         p[$];
        logic [63:0] bits;
        exp_t        e;
        int          nblk;
        p = msg;
        bits = 64'(msg.size()) * 64'd8 + 64'(pre) * 64'd512;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int w = 0; w < 16; w++) begin
                e.blk[32*w +: 32] = {p[64*b+4*w], p[64*b+4*w+1], p[64*b+4*w+2], p[64*b+4*w+3]};
            end
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int  cnt;
        bit  acc;
        if (gap_en && ($urandom % 3 == 0)) begin
            repeat (1 + $urandom % 2) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_data  = d;
        bus.in_bytes = nb;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        cnt = 0;
        acc = 1'b0;
        while (!acc && cnt < 2000) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            cnt++;
        end
        if (!acc) chk("word_accept_timeout", 1'b0, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_msg(input u8_t msg[$], input int pre, input int extra0);
        int          len;
        int          nw;
        int          nb;
        logic [31:0] d;
        bit          add0;
        len = msg.size();
        model_push(msg, pre);
        pre_blocks = 8'(pre);
        add0 = (len % 4 == 0) && (len != 0) &&
               ((extra0 == 1) || ((extra0 == 2) && ($urandom % 2 == 1)));
        nw = (len + 3) / 4;
        if (len == 0) send_word($urandom, 3'd0, 1'b1);
        for (int i = 0; i < nw; i++) begin
            nb = len - 4 * i;
            if (nb > 4) nb = 4;
            d = $urandom;
            for (int k = 0; k < nb; k++) d[31-8*k -: 8] = msg[4*i+k];
            if (i == nw - 1 && !add0) send_word(d, 3'(nb), 1'b1);
            else                      send_word(d, 3'($urandom), 1'b0);
        end
        if (add0) send_word($urandom, 3'd0, 1'b1);
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 5000) begin
            @(posedge clk);
            cnt++;
        end
        chk("drain", 512'(exp_q.size()), 512'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic measure_latency(input string tag, input int want);
        int lat;
        lat = 0;
        @(negedge clk);
        while (!bus.blk_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk(tag, 512'(lat), 512'(want));
    endtask

    function automatic void make_msg(output u8_t m[$], input int len, input int seq);
        m = {};
        for (int i = 0; i < len; i++) m.push_back(seq != 0 ? 8'(i) : 8'($urandom));
    endfunction

    // Output monitor: every cycle the block is offered it must equal the model's head
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.blk_valid) begin
                chk("in_ready_in_emit", bus.in_ready, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("blk_extra", bus.blk_valid, 1'b0);
                end else begin
                    e = exp_q[0];
                    chk("blk_data",  bus.blk_o,     e.blk);
                    chk("blk_first", bus.blk_first, e.first);
                    chk("blk_last",  bus.blk_last,  e.last);
                    if (bus.blk_ready) begin
                        last_blk = bus.blk_o;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : rdy
        bus.blk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.blk_ready = 1'b1;
                1:       bus.blk_ready = ($urandom % 3) != 0;
                default: bus.blk_ready = 1'b0;
            endcase
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        u8_t m[$];
        n_tests = 0;
        n_fail = 0;
        rdy_mode = 0;
        gap_en = 1'b0;
        pre_blocks = 8'd0;
        last_blk = '0;
        bus.in_data = '0;
        bus.in_bytes = '0;
        bus.in_last = 1'b0;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk("rst_blk_valid", bus.blk_valid, 1'b0);
        chk("rst_blk_o",     bus.blk_o,     512'd0);
        chk("rst_blk_last",  bus.blk_last,  1'b0);
        chk("rst_blk_first", bus.blk_first, 1'b1);
        @(posedge clk);
        #1;

        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 0, 0);
        measure_latency("abc_latency", 15);
        drain();
        chk("abc_w0",  last_blk[31:0],    32'h6162_6380);
        chk("abc_w15", last_blk[511:480], 32'h0000_0018);

        m = {};
        send_msg(m, 0, 0);
        drain();
        chk("empty_w0", last_blk[31:0], 32'h8000_0000);

        make_msg(m, 55, 0);
        send_msg(m, 0, 0);
        drain();
        chk("b55_w15", last_blk[511:480], 32'h0000_01B8);
        chk("b55_w13_lo", last_blk[13*32 +: 8], 8'h80);

        make_msg(m, 56, 0);
        send_msg(m, 0, 0);
        drain();
        chk("b56_w15", last_blk[511:480], 32'h0000_01C0);

        // 64 bytes with the first block held back for 10 cycles
        rdy_mode = 2;
        make_msg(m, 64, 1);
        send_msg(m, 0, 0);
        measure_latency("full_latency", 0);
        repeat (10) @(negedge clk);
        chk("bp_valid_held", bus.blk_valid, 1'b1);
        rdy_mode = 0;
        drain();
        chk("b64_w0",  last_blk[31:0],    32'h8000_0000);
        chk("b64_w15", last_blk[511:480], 32'h0000_0200);

        // reset part way through a message: nothing from it may appear
        for (int i = 0; i < 5; i++) send_word($urandom, 3'd4, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_in_ready",  bus.in_ready,  1'b1);
        chk("rstmid_blk_valid", bus.blk_valid, 1'b0);
        chk("rstmid_blk_o",     bus.blk_o,     512'd0);
        @(posedge clk);
        #1;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 0, 0);
        drain();
        chk("rstmid_abc_w15", last_blk[511:480], 32'h0000_0018);

`ifdef SHA256_PAD_PRELOAD_EN
        send_msg(m, 1, 0);
        drain();
        chk("pre_abc_w15", last_blk[511:480], 32'h0000_0218);
        for (int i = 0; i < 6; i++) begin
            make_msg(m, $urandom_range(0, 130), 0);
            send_msg(m, $urandom_range(0, 255), 2);
        end
        drain();
        pre_blocks = 8'd0;
`endif

        rdy_mode = 1;
        gap_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            make_msg(m, $urandom_range(0, 140), 0);
            send_msg(m, 0, 2);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
